// File: rtl/uart_tx_arb_if.sv
// Byte-request, UART-launch and status signals shared by uart_tx_arb and whoever drives it.
// The slave modport is the arbiter's view; the master modport is the requesters' and UART's view.
interface uart_tx_arb_if;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       transmit;
    logic [7:0] data_tx;
    logic       busy_tx;
    logic       grant_id;
    logic       timeout;

    modport master (
        output req0, data0, req1, data1, busy_tx,
        input  ack0, ack1, transmit, data_tx, grant_id, timeout
    );

    modport slave (
        input  req0, data0, req1, data1, busy_tx,
        output ack0, ack1, transmit, data_tx, grant_id, timeout
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter handing bytes from two requesters to one UART; transmit+ack 1 cycle after a request is seen in IDLE.
// Requests are held off while busy_tx is high; optional wait abort under macro UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 8191
) (
    input  logic          clk,
    input  logic          nRst,
    uart_tx_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] data_tx_q, data_tx_d;
    logic       grant_id_q, grant_id_d;
    logic       last_q, last_d;
    logic       winner;
    logic       in_wait;
    logic       wait_expired;

    // On a tie the requester that was not served last takes the UART.
    assign winner  = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    assign in_wait = (state_q == WAIT_START) || (state_q == WAIT_DONE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wait_expired = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) && ((state_d == WAIT_START) || (state_d == WAIT_DONE))) begin
            cnt_d = '0;
        end else if (in_wait && !wait_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        data_tx_d  = data_tx_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if ((bus.req0 || bus.req1) && !bus.busy_tx) begin
                    state_d    = LAUNCH;
                    grant_id_d = winner;
                    last_d     = winner;
                    data_tx_d  = winner ? bus.data1 : bus.data0;
                end
            end
            LAUNCH: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                // An expired wait wins over a late busy edge; the grant pointer is kept.
                if (wait_expired) begin
                    state_d = IDLE;
                end else if (bus.busy_tx) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wait_expired || !bus.busy_tx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            data_tx_q  <= 8'h00;
            grant_id_q <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            data_tx_q  <= data_tx_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
        end
    end

    assign bus.transmit = (state_q == LAUNCH);
    assign bus.ack0     = (state_q == LAUNCH) && !grant_id_q;
    assign bus.ack1     = (state_q == LAUNCH) &&  grant_id_q;
    assign bus.data_tx  = data_tx_q;
    assign bus.grant_id = grant_id_q;
    assign bus.timeout  = wait_expired;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized requesters and a reactive UART,
// all checked every cycle against a transfer-level model of the arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nRst;
    uart_tx_arb_if bus();

    uart_tx_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Transfer-level reference: one byte in flight at a time, released once the UART has
    // been seen busy and then idle again, or after TO cycles of waiting on either edge.
    typedef struct packed {
        logic        launch;
        logic        win;
        logic        last;
        logic        inflight;
        logic        done_ph;
        logic [7:0]  data;
        logic [15:0] age;
    } m_t;

    localparam m_t M_RST = '{launch: 1'b0, win: 1'b0, last: 1'b1, inflight: 1'b0,
                             done_ph: 1'b0, data: 8'h00, age: 16'd0};

    m_t m;

    function automatic m_t model_next(input m_t s, input logic r0, input logic r1,
                                      input logic [7:0] d0, input logic [7:0] d1,
                                      input logic bz);
        m_t n = s;
        if (s.launch) begin
            n.launch   = 1'b0;
            n.inflight = 1'b1;
            n.done_ph  = 1'b0;
            n.age      = 16'd0;
        end else if (s.inflight) begin
            if (TO_EN && (s.age == 16'(TO))) begin
                n.inflight = 1'b0;
            end else if (!s.done_ph && bz) begin
                n.done_ph = 1'b1;
                n.age     = 16'd0;
            end else if (s.done_ph && !bz) begin
                n.inflight = 1'b0;
            end else begin
                n.age = s.age + 16'd1;
            end
        end else if ((r0 || r1) && !bz) begin
            n.win    = (r0 && r1) ? ~s.last : r1;
            n.last   = n.win;
            n.data   = n.win ? d1 : d0;
            n.launch = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m <= M_RST;
        end else begin
            m <= model_next(m, bus.req0, bus.req1, bus.data0, bus.data1, bus.busy_tx);
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int to_cnt = 0;
    int last_tx_cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.transmit === 1'b1) tx_cnt++;
        if (bus.timeout === 1'b1) to_cnt++;
        if (nRst) begin
            chk("transmit", 32'(bus.transmit), 32'(m.launch));
            chk("ack0", 32'(bus.ack0), 32'(m.launch & ~m.win));
            chk("ack1", 32'(bus.ack1), 32'(m.launch & m.win));
            chk("timeout", 32'(bus.timeout),
                32'(TO_EN && m.inflight && (m.age == 16'(TO))));
            if (m.launch) begin
                chk("data_tx", 32'(bus.data_tx), 32'(m.data));
                chk("grant_id", 32'(bus.grant_id), 32'(m.win));
            end
        end
    endtask

    task automatic wait_tx(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.transmit && n < max);
        if (!bus.transmit) chk("wait_tx_bound", 32'd0, 32'd1);
    endtask

    // UART busy for exactly one cycle right after the launch: the fastest legal turnaround.
    task automatic uart_resp();
        tick();
        bus.busy_tx = 1'b1;
        tick();
        bus.busy_tx = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_transmit"}, 32'(bus.transmit), 32'd0);
        chk({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
        chk({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        chk({tag, "_data_tx"}, 32'(bus.data_tx), 32'h00);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
    endtask

    task automatic rand_step(input bit gen);
        if (bus.req0) begin
            if (bus.ack0) begin
                if (gen && $urandom_range(0, 1) == 1) bus.data0 = 8'($urandom);
                else bus.req0 = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0 = 1'b0;
            end
        end else if (gen && $urandom_range(0, 2) == 0) begin
            bus.req0  = 1'b1;
            bus.data0 = 8'($urandom);
        end
        if (bus.req1) begin
            if (bus.ack1) begin
                if (gen && $urandom_range(0, 1) == 1) bus.data1 = 8'($urandom);
                else bus.req1 = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1 = 1'b0;
            end
        end else if (gen && $urandom_range(0, 2) == 0) begin
            bus.req1  = 1'b1;
            bus.data1 = 8'($urandom);
        end
        if (bus.transmit) begin
            rise_cnt = $urandom_range(1, 3);
        end else if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                bus.busy_tx = 1'b1;
                fall_cnt = $urandom_range(1, 6);
            end
        end else if (fall_cnt > 0) begin
            fall_cnt--;
            if (fall_cnt == 0) bus.busy_tx = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tx0;
        int to0;
        logic [7:0] got [3];

        bus.req0 = 1'b0; bus.data0 = 8'h00;
        bus.req1 = 1'b0; bus.data1 = 8'h00;
        bus.busy_tx = 1'b0;
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        nRst = 1'b1;
        tick();

        // Single requester, slow UART.
        bus.req0 = 1'b1; bus.data0 = 8'hA5;
        wait_tx(5, n);
        chk("t1_latency", 32'(n), 32'd1);
        chk("t1_ack0", 32'(bus.ack0), 32'd1);
        chk("t1_ack1", 32'(bus.ack1), 32'd0);
        chk("t1_data", 32'(bus.data_tx), 32'hA5);
        chk("t1_grant", 32'(bus.grant_id), 32'd0);
        bus.req0 = 1'b0;
        tick();
        tick();
        bus.busy_tx = 1'b1;
        tx0 = tx_cnt;
        repeat (100) tick();
        bus.busy_tx = 1'b0;
        repeat (4) tick();
        chk("t1_no_extra_tx", 32'(tx_cnt - tx0), 32'd0);

        // Both requesting from reset: alternation at minimum spacing.
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        bus.req0 = 1'b1; bus.data0 = 8'h11;
        bus.req1 = 1'b1; bus.data1 = 8'h22;
        for (int k = 0; k < 3; k++) begin
            wait_tx(10, n);
            got[k] = bus.data_tx;
            if (k > 0) chk("t2_spacing", 32'(cyc - last_tx_cyc), 32'd4);
            last_tx_cyc = cyc;
            if (k == 2) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            uart_resp();
        end
        chk("t2_order0", 32'(got[0]), 32'h11);
        chk("t2_order1", 32'(got[1]), 32'h22);
        chk("t2_order2", 32'(got[2]), 32'h11);

        // UART busy blocks any grant.
        tick();
        bus.busy_tx = 1'b1;
        bus.req1 = 1'b1; bus.data1 = 8'h3C;
        tx0 = tx_cnt;
        repeat (20) tick();
        chk("t3_blocked", 32'(tx_cnt - tx0), 32'd0);
        bus.busy_tx = 1'b0;
        wait_tx(5, n);
        chk("t3_latency", 32'(n), 32'd1);
        chk("t3_ack1", 32'(bus.ack1), 32'd1);
        chk("t3_data", 32'(bus.data_tx), 32'h3C);
        bus.req1 = 1'b0;
        uart_resp();
        tick();

        // Reset while the UART is busy with requester 0's byte.
        bus.req0 = 1'b1; bus.data0 = 8'h5A;
        wait_tx(5, n);
        bus.req0 = 1'b0;
        tick();
        bus.busy_tx = 1'b1;
        tick();
        tick();
        #3 nRst = 1'b0;
        #1 chk_reset_outputs("t4_async");
        bus.busy_tx = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        tx0 = tx_cnt;
        repeat (5) tick();
        chk("t4_no_tx_after_release", 32'(tx_cnt - tx0), 32'd0);
        bus.req0 = 1'b1; bus.data0 = 8'h33;
        bus.req1 = 1'b1; bus.data1 = 8'h44;
        wait_tx(5, n);
        chk("t4_tie_data", 32'(bus.data_tx), 32'h33);
        chk("t4_tie_grant", 32'(bus.grant_id), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        uart_resp();
        tick();

        // UART never reacts to the launch.
        bus.req0 = 1'b1; bus.data0 = 8'h77;
        wait_tx(5, n);
        bus.req0 = 1'b0;
        to0 = to_cnt;
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.timeout && n < 40);
        chk("t5_timeout_after", 32'(n), 32'd17);
        chk("t5_timeout_count", 32'(to_cnt - to0), 32'd1);
        bus.req1 = 1'b1; bus.data1 = 8'h66;
        wait_tx(5, n);
        chk("t5_regrant_latency", 32'(n), 32'd2);
        chk("t5_regrant_data", 32'(bus.data_tx), 32'h66);
        bus.req1 = 1'b0;
        uart_resp();
`else
        repeat (40) tick();
        chk("t5_no_timeout", 32'(to_cnt - to0), 32'd0);
        bus.req1 = 1'b1; bus.data1 = 8'h66;
        tx0 = tx_cnt;
        repeat (5) tick();
        chk("t5_still_waiting", 32'(tx_cnt - tx0), 32'd0);
        bus.busy_tx = 1'b1;
        tick();
        bus.busy_tx = 1'b0;
        wait_tx(10, n);
        chk("t5_late_data", 32'(bus.data_tx), 32'h66);
        bus.req1 = 1'b0;
        uart_resp();
`endif
        tick();

        // Randomized traffic against the model.
        tx0 = tx_cnt;
        rise_cnt = 0;
        fall_cnt = 0;
        repeat (2500) begin
            tick();
            rand_step(1'b1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (30) begin
            tick();
            rand_step(1'b0);
        end
        chk("rand_traffic_seen", 32'(tx_cnt - tx0 > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
